// File: rtl/ibex_locked_csr_bank.sv
// Bank of lockable custom CSRs (for example memory-encryption key words) beside the CSR file.
// Data CSRs support read/write/set/clear; a sticky lock CSR write-protects entries; zeroise wipes all data.
module ibex_locked_csr_bank #(
  parameter int unsigned       NumRegs    = 4,
  parameter int unsigned       Width      = 32,
  parameter logic [11:0]       BaseAddr   = 12'h7C0,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       csr_access_i,
  input  logic [11:0]                csr_addr_i,
  input  logic [1:0]                 csr_op_i,
  input  logic [Width-1:0]           csr_wdata_i,
  output logic                       csr_hit_o,
  output logic [Width-1:0]           csr_rdata_o,
  output logic                       csr_err_o,
  input  logic                       zeroise_req_i,
  output logic                       busy_o,
  output logic                       zeroise_done_o,
  output logic [NumRegs*Width-1:0]   reg_value_o,
  output logic [NumRegs-1:0]         reg_locked_o,
  output logic [1:0]                 dbg_state_o
);

  localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);
  localparam logic [12:0] BaseExt = {1'b0, BaseAddr};
  localparam logic [12:0] LockAddr = BaseExt + 13'(NumRegs);

  localparam logic [1:0] OpRead  = 2'd0;
  localparam logic [1:0] OpWrite = 2'd1;
  localparam logic [1:0] OpSet   = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWipe = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                wipe_idx_q, wipe_idx_d;
  logic [NumRegs-1:0][Width-1:0]  data_q, data_d;
  logic [NumRegs-1:0]             lock_q, lock_d;

  logic [12:0]        addr_ext;
  logic               data_hit;
  logic               lock_hit;
  logic [NumRegs-1:0] data_sel;
  logic               sel_locked;
  logic               busy;
  logic               data_wr_en;
  logic               lock_wr_en;

  // Address decode; 13-bit arithmetic keeps BaseAddr+NumRegs from wrapping.
  always_comb begin
    addr_ext = {1'b0, csr_addr_i};
    data_hit = csr_access_i && (addr_ext >= BaseExt) && (addr_ext < LockAddr);
    lock_hit = csr_access_i && (addr_ext == LockAddr);
    data_sel = '0;
    for (int i = 0; i < int'(NumRegs); i++) begin
      data_sel[i] = data_hit && (addr_ext == BaseExt + 13'(i));
    end
    sel_locked = |(data_sel & lock_q);
  end

  assign busy = (state_q != StIdle);

  // Modifying ops on a locked entry are rejected; reads always pass.
  assign data_wr_en = data_hit && !busy && !sel_locked && (csr_op_i != OpRead);
  assign lock_wr_en = lock_hit && !busy && ((csr_op_i == OpWrite) || (csr_op_i == OpSet));

  always_comb begin
    csr_hit_o   = data_hit || lock_hit;
    csr_rdata_o = '0;
    if (data_hit) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        if (data_sel[i]) begin
          csr_rdata_o = data_q[i];
        end
      end
    end else if (lock_hit) begin
      csr_rdata_o[NumRegs-1:0] = lock_q;
    end
    csr_err_o = ((data_hit || lock_hit) && busy) ||
                (data_hit && sel_locked && (csr_op_i != OpRead));
  end

  // The wipe ignores locks; CSR writes cannot coincide with it because busy blocks them.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < int'(NumRegs); i++) begin
      if ((state_q == StWipe) && (wipe_idx_q == IdxW'(i))) begin
        data_d[i] = ResetValue;
      end else if (data_wr_en && data_sel[i]) begin
        unique case (csr_op_i)
          OpWrite: data_d[i] = csr_wdata_i;
          OpSet:   data_d[i] = data_q[i] | csr_wdata_i;
          OpClear: data_d[i] = data_q[i] & ~csr_wdata_i;
          default: data_d[i] = data_q[i];
        endcase
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (lock_wr_en) begin
      lock_d = lock_q | csr_wdata_i[NumRegs-1:0];
    end
  end

  // Wipe FSM: next-state logic.
  always_comb begin
    state_d    = state_q;
    wipe_idx_d = wipe_idx_q;
    unique case (state_q)
      StIdle: begin
        wipe_idx_d = '0;
        if (zeroise_req_i) begin
          state_d = StWipe;
        end
      end
      StWipe: begin
        wipe_idx_d = wipe_idx_q + 1'b1;
        if (wipe_idx_q == LastIdx) begin
          state_d    = StDone;
          wipe_idx_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d    = StIdle;
        wipe_idx_d = '0;
      end
    endcase
  end

  // Wipe FSM: outputs.
  always_comb begin
    busy_o         = busy;
    zeroise_done_o = (state_q == StDone);
    dbg_state_o    = state_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      wipe_idx_q <= '0;
      data_q     <= {NumRegs{ResetValue}};
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      wipe_idx_q <= wipe_idx_d;
      data_q     <= data_d;
      lock_q     <= lock_d;
    end
  end

  assign reg_value_o  = data_q;
  assign reg_locked_o = lock_q;

endmodule

// File: tb/tb_ibex_locked_csr_bank.sv
// Table-driven bench for ibex_locked_csr_bank (NumRegs=4, Width=32, BaseAddr=0x7C0).
// Each row drives one cycle's inputs and checks the outputs observed before the next edge.
module tb_ibex_locked_csr_bank;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] W = 2'd1;
  localparam logic [1:0] S = 2'd2;
  localparam logic [1:0] C = 2'd3;

  logic          clk;
  logic          rst;
  logic          csr_access;
  logic [11:0]   csr_addr;
  logic [1:0]    csr_op;
  logic [31:0]   csr_wdata;
  logic          csr_hit;
  logic [31:0]   csr_rdata;
  logic          csr_err;
  logic          zeroise_req;
  logic          busy;
  logic          zeroise_done;
  logic [127:0]  reg_value;
  logic [3:0]    reg_locked;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  int row    = 0;

  ibex_locked_csr_bank dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .csr_access_i   (csr_access),
    .csr_addr_i     (csr_addr),
    .csr_op_i       (csr_op),
    .csr_wdata_i    (csr_wdata),
    .csr_hit_o      (csr_hit),
    .csr_rdata_o    (csr_rdata),
    .csr_err_o      (csr_err),
    .zeroise_req_i  (zeroise_req),
    .busy_o         (busy),
    .zeroise_done_o (zeroise_done),
    .reg_value_o    (reg_value),
    .reg_locked_o   (reg_locked),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         acc;
    logic [11:0]  addr;
    logic [1:0]   op;
    logic [31:0]  wdata;
    logic         zreq;
    logic         chk;
    logic         e_hit;
    logic [31:0]  e_rdata;
    logic         e_err;
    logic         e_busy;
    logic         e_done;
    logic [3:0]   e_locked;
    logic [127:0] e_vals;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [127:0] vals(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic vec_t mk(input logic rst_v, input logic acc, input logic [11:0] addr,
                              input logic [1:0] op, input logic [31:0] wdata, input logic zreq,
                              input logic chk, input logic e_hit, input logic [31:0] e_rdata,
                              input logic e_err, input logic e_busy, input logic e_done,
                              input logic [3:0] e_locked, input logic [127:0] e_vals);
    vec_t v;
    v.rst = rst_v; v.acc = acc; v.addr = addr; v.op = op; v.wdata = wdata; v.zreq = zreq;
    v.chk = chk; v.e_hit = e_hit; v.e_rdata = e_rdata; v.e_err = e_err; v.e_busy = e_busy;
    v.e_done = e_done; v.e_locked = e_locked; v.e_vals = e_vals;
    return v;
  endfunction

  // Driver: inputs change at the falling edge, outputs are sampled 2ns later.
  task automatic drive(input logic rst_v, input logic acc, input logic [11:0] addr,
                       input logic [1:0] op, input logic [31:0] wdata, input logic zreq);
    @(negedge clk);
    rst = rst_v; csr_access = acc; csr_addr = addr; csr_op = op; csr_wdata = wdata;
    zeroise_req = zreq;
    #2;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_row(input vec_t v);
    check("hit",    128'(csr_hit),      128'(v.e_hit));
    check("rdata",  128'(csr_rdata),    128'(v.e_rdata));
    check("err",    128'(csr_err),      128'(v.e_err));
    check("busy",   128'(busy),         128'(v.e_busy));
    check("done",   128'(zeroise_done), 128'(v.e_done));
    check("locked", 128'(reg_locked),   128'(v.e_locked));
    check("values", reg_value,          v.e_vals);
  endtask

  logic [127:0] v1, v2;
  bit           seen_busy;

  initial begin
    rst = 1'b1; csr_access = 1'b0; csr_addr = '0; csr_op = R; csr_wdata = '0; zeroise_req = 1'b0;
    v1 = vals(32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    v2 = vals(32'h0000FF00, 32'hDEADBEEF, 32'h0, 32'h0);

    // rst acc addr op wdata zreq | chk hit rdata err busy done locked values
    tbl.push_back(mk(1, 0, 12'h000, R, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 4'h0, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 4'h0, '0));
    tbl.push_back(mk(0, 1, 12'h7C1, W, 32'hDEADBEEF, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, '0));
    tbl.push_back(mk(0, 1, 12'h7C1, R, 32'h0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 4'h0, v1));
    tbl.push_back(mk(0, 1, 12'h7C0, S, 32'h0000FFFF, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, v1));
    tbl.push_back(mk(0, 1, 12'h7C0, C, 32'h000000FF, 0, 1, 1, 32'h0000FFFF, 0, 0, 0, 4'h0,
                     vals(32'h0000FFFF, 32'hDEADBEEF, 32'h0, 32'h0)));
    tbl.push_back(mk(0, 1, 12'h7C0, R, 32'h0, 0, 1, 1, 32'h0000FF00, 0, 0, 0, 4'h0, v2));
    tbl.push_back(mk(0, 1, 12'h7C4, W, 32'h2, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, v2));
    tbl.push_back(mk(0, 1, 12'h7C1, W, 32'h1, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7C1, R, 32'h0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7C4, C, 32'hF, 0, 1, 1, 32'h2, 0, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7C4, R, 32'h0, 0, 1, 1, 32'h2, 0, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7C1, S, 32'h1, 0, 1, 1, 32'hDEADBEEF, 1, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7C5, W, 32'h1, 0, 1, 0, 32'h0, 0, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7BF, W, 32'h1, 0, 1, 0, 32'h0, 0, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 0, 12'h7C0, W, 32'h1234, 0, 1, 0, 32'h0, 0, 0, 0, 4'h2, v2));
    tbl.push_back(mk(0, 1, 12'h7C0, R, 32'h0, 0, 1, 1, 32'h0000FF00, 0, 0, 0, 4'h2, v2));
    // Fresh reset, load 1..4, lock word 0, then wipe.
    tbl.push_back(mk(1, 0, 12'h000, R, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 4'h0, '0));
    tbl.push_back(mk(0, 1, 12'h7C0, W, 32'h1, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, '0));
    tbl.push_back(mk(0, 1, 12'h7C1, W, 32'h2, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, vals(1, 0, 0, 0)));
    tbl.push_back(mk(0, 1, 12'h7C2, W, 32'h3, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, vals(1, 2, 0, 0)));
    tbl.push_back(mk(0, 1, 12'h7C3, W, 32'h4, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, vals(1, 2, 3, 0)));
    tbl.push_back(mk(0, 1, 12'h7C4, W, 32'h1, 0, 1, 1, 32'h0, 0, 0, 0, 4'h0, vals(1, 2, 3, 4)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 0, 0, 4'h1, vals(1, 2, 3, 4)));
    tbl.push_back(mk(0, 1, 12'h7C2, R, 32'h0, 0, 1, 1, 32'h3, 1, 1, 0, 4'h1, vals(1, 2, 3, 4)));
    tbl.push_back(mk(0, 1, 12'h7C3, W, 32'hFF, 0, 1, 1, 32'h4, 1, 1, 0, 4'h1, vals(0, 2, 3, 4)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h1, vals(0, 0, 3, 4)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h1, vals(0, 0, 0, 4)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 4'h1, '0));
    // Request together with a write, held high through DONE so the wipe restarts.
    tbl.push_back(mk(0, 1, 12'h7C2, W, 32'hAA, 1, 1, 1, 32'h0, 0, 0, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 1, 0, 4'h1, vals(0, 0, 32'hAA, 0)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 1, 0, 4'h1, vals(0, 0, 32'hAA, 0)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 1, 0, 4'h1, vals(0, 0, 32'hAA, 0)));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 1, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 1, 1, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 1, 1, 0, 32'h0, 0, 0, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 0, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 1, 1, 4'h1, '0));
    tbl.push_back(mk(0, 0, 12'h000, R, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 4'h1, '0));

    foreach (tbl[i]) begin
      row = i;
      drive(tbl[i].rst, tbl[i].acc, tbl[i].addr, tbl[i].op, tbl[i].wdata, tbl[i].zreq);
      if (tbl[i].chk) check_row(tbl[i]);
    end

    // Reset asserted in the second wipe cycle.
    row = 1000;
    drive(0, 1, 12'h7C3, W, 32'h55, 0);
    check("pre_wipe_err", 128'(csr_err), 128'(0));
    drive(0, 0, 12'h000, R, 32'h0, 1);
    check("pre_wipe_vals", reg_value, vals(0, 0, 0, 32'h55));
    seen_busy = 0;
    for (int k = 0; k < 8 && !seen_busy; k++) begin
      drive(0, 0, 12'h000, R, 32'h0, 0);
      seen_busy = busy;
    end
    check("wipe_started", 128'(seen_busy), 128'(1));
    drive(1, 0, 12'h000, R, 32'h0, 0);
    check("second_wipe_busy", 128'(busy), 128'(1));
    check("second_wipe_vals", reg_value, vals(0, 0, 0, 32'h55));
    drive(0, 1, 12'h7C5, R, 32'h0, 0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(zeroise_done), 128'(0));
    check("rst_locked", 128'(reg_locked), 128'(0));
    check("rst_vals", reg_value, '0);
    check("miss_hi_hit", 128'(csr_hit), 128'(0));
    check("miss_hi_rdata", 128'(csr_rdata), 128'(0));
    drive(0, 1, 12'h7BF, R, 32'h0, 0);
    check("miss_lo_hit", 128'(csr_hit), 128'(0));
    check("miss_lo_rdata", 128'(csr_rdata), 128'(0));
    check("no_done_pulse", 128'(zeroise_done), 128'(0));
    drive(0, 0, 12'h000, R, 32'h0, 0);
    check("idle_after_rst", 128'(busy | zeroise_done), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
